// File: rtl/tone_pkg.sv
// rtl/tone_pkg.sv - shared widths, ROM scaling and quadrant encoding for the tone source
package tone_pkg;
  localparam int DATA_W  = 16;
  localparam int PHASE_W = 24;
  localparam int LUT_AW  = 8;
  localparam int DIV_W   = 16;
  localparam int AMP_MAX = 2047;

  typedef enum logic [1:0] {
    QUAD_0 = 2'd0,
    QUAD_1 = 2'd1,
    QUAD_2 = 2'd2,
    QUAD_3 = 2'd3
  } quadrant_t;

  // Second and fourth quadrants read the quarter table backwards.
  function automatic logic quad_mirror(input quadrant_t q);
    return (q == QUAD_1) || (q == QUAD_3);
  endfunction

  // Lower half of the cycle is the negated table.
  function automatic logic quad_negate(input quadrant_t q);
    return (q == QUAD_2) || (q == QUAD_3);
  endfunction

  // Elaboration-time round(amp*sin(pi/2*i/n)) by Taylor series; only used to build constants.
  function automatic int quarter_sine(input int i, input int n, input int amp);
    real x;
    real term;
    real sum;
    x    = 3.14159265358979323846 / 2.0 * i / n;
    term = x;
    sum  = x;
    for (int k = 1; k < 14; k++) begin
      term = -term * x * x / ((2 * k) * (2 * k + 1));
      sum  = sum + term;
    end
    return $rtoi(amp * sum + 0.5);
  endfunction
endpackage

// File: rtl/quarter_sine_rom.sv
// rtl/quarter_sine_rom.sv - synchronous-read quarter-wave sine table with N+1 entries
module quarter_sine_rom #(
  parameter int LUT_AW = tone_pkg::LUT_AW,
  parameter int DATA_W = tone_pkg::DATA_W,
  parameter int AMP    = tone_pkg::AMP_MAX
) (
  input  logic              clk,
  input  logic [LUT_AW:0]   addr,
  output logic [DATA_W-1:0] data
);
  import tone_pkg::*;

  localparam int N = 1 << LUT_AW;

  logic [DATA_W-1:0] tab [0:N];

  // Entry N holds the peak so the mirrored quadrants can address N-i without a special case.
  for (genvar g = 0; g <= N; g++) begin : g_tab
    localparam int VAL = quarter_sine(g, N, AMP);
    assign tab[g] = DATA_W'(VAL);
  end

  always_ff @(posedge clk) begin
    data <= tab[addr];
  end
endmodule

// File: rtl/tone_sample_source.sv
// rtl/tone_sample_source.sv - DDS test-tone source: rate divider, phase accumulator, 3-stage sine pipeline
module tone_sample_source #(
  parameter int DATA_W  = tone_pkg::DATA_W,
  parameter int PHASE_W = tone_pkg::PHASE_W,
  parameter int LUT_AW  = tone_pkg::LUT_AW,
  parameter int DIV_W   = tone_pkg::DIV_W,
  parameter int AMP_MAX = tone_pkg::AMP_MAX
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [DIV_W-1:0]   rate_div,
  input  logic [PHASE_W-1:0] phase_inc,
  input  logic [3:0]         amp_shift,
  output logic [DATA_W-1:0]  data_out,
  output logic               sample_valid
);
  import tone_pkg::*;

  localparam logic [LUT_AW:0] N_IDX = (LUT_AW + 1)'(1 << LUT_AW);

  logic [DIV_W-1:0]   cnt;
  logic [PHASE_W-1:0] phase;
  logic               tick;
  quadrant_t          quad;
  logic [LUT_AW-1:0]  fine;

  logic               v1;
  logic               neg1;
  logic [LUT_AW:0]    idx1;

  logic               v2;
  logic               neg2;
  logic [DATA_W-1:0]  tab2;

  logic signed [DATA_W-1:0] signed_tab;
  logic signed [DATA_W-1:0] scaled;

  assign tick = enable && (cnt == rate_div);
  assign quad = quadrant_t'(phase[PHASE_W-1 -: 2]);
  assign fine = phase[PHASE_W-3 -: LUT_AW];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt   <= '0;
      phase <= '0;
    end else begin
      if (!enable || tick) cnt <= '0;
      else                 cnt <= cnt + 1'b1;
      if (tick) phase <= phase + phase_inc;
    end
  end

  // Stage 1: quadrant folding uses the pre-increment phase, so the first sample is sin(0).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1   <= 1'b0;
      neg1 <= 1'b0;
      idx1 <= '0;
    end else begin
      v1 <= tick;
      if (tick) begin
        neg1 <= quad_negate(quad);
        idx1 <= quad_mirror(quad) ? (N_IDX - {1'b0, fine}) : {1'b0, fine};
      end
    end
  end

  quarter_sine_rom #(
    .LUT_AW (LUT_AW),
    .DATA_W (DATA_W),
    .AMP    (AMP_MAX)
  ) u_rom (
    .clk  (clk),
    .addr (idx1),
    .data (tab2)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v2   <= 1'b0;
      neg2 <= 1'b0;
    end else begin
      v2   <= v1;
      neg2 <= neg1;
    end
  end

  assign signed_tab = neg2 ? -$signed(tab2) : $signed(tab2);
  assign scaled     = signed_tab >>> amp_shift;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sample_valid <= 1'b0;
      data_out     <= '0;
    end else begin
      sample_valid <= v2;
      if (v2) data_out <= scaled;
    end
  end
endmodule

// File: tb/tb_tone_sample_source.sv
// tb/tb_tone_sample_source.sv - self-checking bench for tone_sample_source
module tb_tone_sample_source;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] rate_div = 16'd499;
  logic [23:0] phase_inc = 24'd838861;
  logic [3:0]  amp_shift = 4'd0;
  logic [15:0] data_out;
  logic        sample_valid;

  always #5 clk = ~clk;

  tone_sample_source dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .rate_div     (rate_div),
    .phase_inc    (phase_inc),
    .amp_shift    (amp_shift),
    .data_out     (data_out),
    .sample_valid (sample_valid)
  );

  int     compared = 0;
  int     mismatched = 0;
  longint cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    longint due;
    int     val;
  } ev_t;

  ev_t         pend[$];
  longint      since = 0;
  logic [23:0] mphase = '0;
  int          last = 0;
  int          obs_val[$];
  longint      obs_cyc[$];

  // Ideal sine at the 10-bit phase resolution, rounded half away from zero.
  function automatic int model_sample(input logic [23:0] ph);
    real v;
    int  k;
    k = int'(ph >> 14);
    v = 2047.0 * $sin(6.283185307179586 * k / 1024.0);
    return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      chk("reset_valid", longint'(sample_valid), 0);
      chk("reset_data", longint'($signed(data_out)), 0);
      pend.delete();
      since  = 0;
      mphase = '0;
      last   = 0;
    end else begin
      bit  exp_v;
      ev_t ev;
      exp_v = (pend.size() > 0) && (pend[0].due == cyc);
      chk("valid", longint'(sample_valid), longint'(exp_v));
      if (sample_valid) begin
        obs_val.push_back(int'($signed(data_out)));
        obs_cyc.push_back(cyc);
      end
      if (exp_v) begin
        ev   = pend.pop_front();
        last = ev.val >>> amp_shift;
      end
      chk("data", longint'($signed(data_out)), longint'(last));
      if (enable) begin
        if ((since % (longint'(rate_div) + 1)) == longint'(rate_div)) begin
          ev.due = cyc + 3;
          ev.val = model_sample(mphase);
          pend.push_back(ev);
          mphase = mphase + phase_inc;
        end
        since++;
      end else begin
        since = 0;
      end
    end
  end

  function automatic int ov(input int i);
    return (i < obs_val.size()) ? obs_val[i] : -99999;
  endfunction

  function automatic longint oc(input int i);
    return (i < obs_cyc.size()) ? obs_cyc[i] : -99999;
  endfunction

  task automatic wait_pulses(input int n, input int budget, input string name);
    int k = 0;
    while (obs_val.size() < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    chk(name, obs_val.size(), n);
    #1;
  endtask

  task automatic restart(input int rd, input int inc, input int sh);
    @(posedge clk);
    #1 enable = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rst       = 1'b0;
    rate_div  = 16'(rd);
    phase_inc = 24'(inc);
    amp_shift = 4'(sh);
    @(posedge clk);
    #1 rst = 1'b1;
    obs_val.delete();
    obs_cyc.delete();
  endtask

  initial begin
    longint e;
    longint p;
    int     n0;
    int     sq[8];
    int     sq3[8];
    sq  = '{0, 2047, 0, -2047, 0, 2047, 0, -2047};
    sq3 = '{0, 255, 0, -256, 0, 255, 0, -256};

    #100;
    chk("t1_reset_valid", longint'(sample_valid), 0);
    chk("t1_reset_data", longint'($signed(data_out)), 0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 enable = 1'b1;
    e = cyc;
    wait_pulses(21, 11000, "t1_pulses");
    chk("t1_first_val", ov(0), 0);
    chk("t1_quarter", ov(5), 2047);
    chk("t1_half", ov(10), 0);
    chk("t1_three_q", ov(15), -2047);
    chk("t1_period", ov(20), 0);
    chk("t1_first_lat", oc(0) - e, 502);
    chk("t1_spacing", oc(1) - oc(0), 500);

    restart(9, 1 << 22, 0);
    @(posedge clk);
    #1 enable = 1'b1;
    e = cyc;
    wait_pulses(8, 120, "t2_pulses");
    for (int i = 0; i < 8; i++) chk($sformatf("t2_val%0d", i), ov(i), sq[i]);
    chk("t2_first_lat", oc(0) - e, 12);
    chk("t2_spacing", oc(1) - oc(0), 10);

    restart(0, 1 << 22, 0);
    @(posedge clk);
    #1 enable = 1'b1;
    e = cyc;
    wait_pulses(8, 30, "t3_pulses");
    chk("t3_first_lat", oc(0) - e, 3);
    chk("t3_back_to_back", oc(7) - oc(0), 7);
    for (int i = 0; i < 4; i++) chk($sformatf("t3_val%0d", i), ov(i), sq[i]);

    restart(9, 1 << 22, 3);
    @(posedge clk);
    #1 enable = 1'b1;
    wait_pulses(8, 120, "t4_pulses");
    for (int i = 0; i < 8; i++) chk($sformatf("t4_val%0d", i), ov(i), sq3[i]);

    restart(0, 1 << 22, 0);
    @(posedge clk);
    #1 enable = 1'b1;
    repeat (6) @(posedge clk);
    #1 enable = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("t5_inflight", obs_val.size(), 6);
    chk("t5_hold", longint'($signed(data_out)), 2047);
    enable = 1'b1;
    wait_pulses(8, 30, "t5_resume");
    chk("t5_next", ov(6), 0);
    chk("t5_next2", ov(7), -2047);

    restart(9, 1 << 22, 0);
    @(posedge clk);
    #1 enable = 1'b1;
    wait_pulses(2, 60, "t6_pre");
    p = oc(1);
    do begin
      @(posedge clk);
      #1;
    end while (cyc < p + 8);
    rst = 1'b0;
    #1;
    chk("t6_rst_data", longint'($signed(data_out)), 0);
    @(posedge clk);
    #1 rst = 1'b1;
    n0 = obs_val.size();
    repeat (8) @(posedge clk);
    #1;
    chk("t6_discarded", obs_val.size(), n0);
    wait_pulses(n0 + 2, 40, "t6_restart");
    chk("t6_first", ov(n0), 0);
    chk("t6_second", ov(n0 + 1), 2047);

    enable = 1'b0;
    repeat (5) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
